// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the execute ALU through a 2-entry skid buffer.
// 1-cycle latency, in_ready registered; optional ILLEGAL_TRAP_EN adds the registered illegal flag.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              a_sel,
  output logic              b_sel,
  output logic [XLEN-1:0]   imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   out_pc
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(0),  ALU_SRL = CTRL_W'(1),  ALU_SRA = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(3),  ALU_SUB = CTRL_W'(4),  ALU_LUI = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_AUIPC = CTRL_W'(6), ALU_XOR = CTRL_W'(7), ALU_OR = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(9),  ALU_SLT = CTRL_W'(10), ALU_SLTU = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] ALU_BEQ = CTRL_W'(12), ALU_BNE = CTRL_W'(13), ALU_BLT = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] ALU_BGE = CTRL_W'(15), ALU_BLTU = CTRL_W'(16), ALU_BGEU = CTRL_W'(17);
  localparam logic [CTRL_W-1:0] ALU_JAL = CTRL_W'(18), ALU_JALR = CTRL_W'(19), ALU_LOAD = CTRL_W'(20);
  localparam logic [CTRL_W-1:0] ALU_STORE = CTRL_W'(21);

  localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_LOAD = 7'h03, OPC_STORE = 7'h23;

  typedef struct packed {
    logic [CTRL_W-1:0] alu;
    logic              a_sel;
    logic              b_sel;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rw;
    logic              mr;
    logic              mw;
    logic [XLEN-1:0]   pc;
`ifdef ILLEGAL_TRAP_EN
    logic              ill;
`endif
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_SKID} state_t;

  state_t      r_state, w_state_nxt;
  entry_t      r_main, r_skid, w_dec, w_rst_entry;
  logic        r_out_valid, r_in_ready;
  logic        w_accept, w_load_main, w_load_skid, w_skid_to_main, w_bad;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [XLEN-1:0] w_imm_u;

  function automatic logic [CTRL_W-1:0] f3_alu(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  f3_alu = sub ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = sra ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_u = XLEN'({12'b0, in_instr[31:12]});

  always_comb begin
    w_dec     = '0;
    w_bad     = 1'b0;
    w_dec.alu = ALU_ADD;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = in_instr[24:20];
    w_dec.rd  = in_instr[11:7];
    w_dec.pc  = in_pc;
    case (w_op)
      OPC_OP: begin
        w_dec.alu = f3_alu(w_f3, w_f7[5], w_f7[5]);
        w_dec.rw  = 1'b1;
        w_bad     = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        w_dec.alu   = f3_alu(w_f3, 1'b0, w_f7[5]);
        w_dec.b_sel = 1'b1;
        w_dec.rw    = 1'b1;
        w_dec.imm   = XLEN'($signed(w_imm_i));
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_dec.imm = XLEN'({27'b0, in_instr[24:20]});
          w_bad     = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        end
      end
      OPC_LUI: begin
        w_dec.alu = ALU_LUI; w_dec.b_sel = 1'b1; w_dec.imm = w_imm_u; w_dec.rw = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.alu = ALU_AUIPC; w_dec.a_sel = 1'b1; w_dec.b_sel = 1'b1;
        w_dec.imm = w_imm_u;   w_dec.rw = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.a_sel = 1'b1; w_dec.b_sel = 1'b1; w_dec.imm = XLEN'($signed(w_imm_b));
        case (w_f3)
          3'b000:  w_dec.alu = ALU_BEQ;
          3'b001:  w_dec.alu = ALU_BNE;
          3'b100:  w_dec.alu = ALU_BLT;
          3'b101:  w_dec.alu = ALU_BGE;
          3'b110:  w_dec.alu = ALU_BLTU;
          3'b111:  w_dec.alu = ALU_BGEU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        w_dec.alu = ALU_JAL; w_dec.a_sel = 1'b1; w_dec.b_sel = 1'b1;
        w_dec.imm = XLEN'($signed(w_imm_j)); w_dec.rw = 1'b1;
      end
      OPC_JALR: begin
        w_dec.alu = ALU_JALR; w_dec.b_sel = 1'b1; w_dec.imm = XLEN'($signed(w_imm_i));
        w_dec.rw  = 1'b1;     w_bad = (w_f3 != 3'b000);
      end
      OPC_LOAD: begin
        w_dec.alu = ALU_LOAD; w_dec.b_sel = 1'b1; w_dec.imm = XLEN'($signed(w_imm_i));
        w_dec.mr  = 1'b1;     w_dec.rw = 1'b1;
        w_bad     = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_dec.alu = ALU_STORE; w_dec.b_sel = 1'b1; w_dec.imm = XLEN'($signed(w_imm_s));
        w_dec.mw  = 1'b1;      w_bad = (w_f3 > 3'b010);
      end
      default: w_bad = 1'b1;
    endcase
    // Illegal encodings collapse to a side-effect-free ADD.
    if (w_bad) begin
      w_dec.alu = ALU_ADD; w_dec.a_sel = 1'b0; w_dec.b_sel = 1'b0; w_dec.imm = '0;
      w_dec.rw  = 1'b0;    w_dec.mr = 1'b0;    w_dec.mw = 1'b0;
    end
    if (w_dec.rd == 5'd0) w_dec.rw = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_dec.ill = w_bad;
`endif
  end

  always_comb begin
    w_rst_entry     = '0;
    w_rst_entry.alu = ALU_ADD;
  end

  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin w_load_main = 1'b1; w_state_nxt = S_ONE; end
        S_ONE: begin
          if (out_ready) begin
            if (w_accept) w_load_main = 1'b1;
            else          w_state_nxt = S_EMPTY;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_SKID;
          end
        end
        S_SKID:  if (out_ready) begin w_skid_to_main = 1'b1; w_state_nxt = S_ONE; end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_SKID);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= w_rst_entry;
      r_skid <= w_rst_entry;
    end else begin
      if (w_load_main)         r_main <= w_dec;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_dec;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_main.alu;
  assign a_sel     = r_main.a_sel;
  assign b_sel     = r_main.b_sel;
  assign imm       = r_main.imm;
  assign rs1       = r_main.rs1;
  assign rs2       = r_main.rs2;
  assign rd        = r_main.rd;
  assign reg_write = r_main.rw;
  assign mem_read  = r_main.mr;
  assign mem_write = r_main.mw;
  assign out_pc    = r_main.pc;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = r_main.ill;
`endif

endmodule
